// File: rtl/dram_pkg.sv
// Shared types and default DDR4 timings for the per-bank timer and refresh scheduler.
package dram_pkg;

    localparam int BANK_GROUP_BITS  = 2;
    localparam int BANK_BITS        = 2;
    localparam int DEF_NUM_BANKS    = 1 << (BANK_GROUP_BITS + BANK_BITS);
    localparam int DEF_ROW_W        = 15;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_T_RCD        = 10;
    localparam int DEF_T_RP         = 10;
    localparam int DEF_T_RAS        = 45;
    localparam int DEF_T_RC         = 55;
    localparam int DEF_T_WL         = 10;
    localparam int DEF_T_RL         = 10;
    localparam int DEF_T_BURST      = 4;
    localparam int DEF_T_WR         = 13;
    localparam int DEF_T_WTR        = 5;
    localparam int DEF_T_RFC        = 172;
    localparam int DEF_T_REFI       = 250;
    localparam int DEF_MAX_POSTPONE = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ACT  = 3'd1,
        OP_RD   = 3'd2,
        OP_WR   = 3'd3,
        OP_PRE  = 3'd4,
        OP_PREA = 3'd5,
        OP_REF  = 3'd6
    } bank_op_t;

    typedef enum logic [2:0] {
        BS_IDLE        = 3'd0,
        BS_ACTIVATING  = 3'd1,
        BS_ACTIVE      = 3'd2,
        BS_PRECHARGING = 3'd3,
        BS_REFRESHING  = 3'd4
    } bank_state_t;

    // Timers reload with T-1, so every timing must be at least 1 and fit the counter.
    function automatic bit fits_cnt(input int t, input int w);
        return (t >= 1) && (t < (1 << w));
    endfunction

endpackage

// File: rtl/dram_bank_timer_if.sv
// Command/query bus between the command scheduler (master) and the bank timer (slave).
interface dram_bank_timer_if
    import dram_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ROW_W     = DEF_ROW_W
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                 cmd_valid;
    bank_op_t             cmd_op;
    logic [BANK_W-1:0]    cmd_bank;
    logic [ROW_W-1:0]     cmd_row;

    logic                 can_act;
    logic                 can_rd;
    logic                 can_wr;
    logic                 can_pre;
    logic                 can_prea;
    logic                 can_ref;
    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_W-1:0]     open_row;
    logic                 ref_req;
    logic                 ref_urgent;
    logic                 err_illegal;
    logic                 ref_overflow;

    modport master (
        output cmd_valid, cmd_op, cmd_bank, cmd_row,
        input  can_act, can_rd, can_wr, can_pre, can_prea, can_ref,
        input  bank_open, open_row, ref_req, ref_urgent, err_illegal, ref_overflow
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bank, cmd_row,
        output can_act, can_rd, can_wr, can_pre, can_prea, can_ref,
        output bank_open, open_row, ref_req, ref_urgent, err_illegal, ref_overflow
    );

endinterface

// File: rtl/dram_bank_fsm.sv
// One bank's state, open row and same-bank timers (tRCD/tRP/tRAS/tRC/write recovery).
module dram_bank_fsm
    import dram_pkg::*;
#(
    parameter int ROW_W    = DEF_ROW_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RAS    = DEF_T_RAS,
    parameter int T_RC     = DEF_T_RC,
    parameter int T_WR_REC = DEF_T_WL + DEF_T_BURST + DEF_T_WR
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             do_act,
    input  logic             do_wr,
    input  logic             do_pre,
    input  logic             do_ref,
    input  logic             rfc_done,
    input  logic [ROW_W-1:0] act_row,
    output bank_state_t      state,
    output logic [ROW_W-1:0] row,
    output logic             act_tmr_ok,
    output logic             pre_tmr_ok
);

    bank_state_t      state_q;
    bank_state_t      state_d;
    logic [ROW_W-1:0] row_q;
    logic [CNT_W-1:0] rcd_q;
    logic [CNT_W-1:0] rp_q;
    logic [CNT_W-1:0] ras_q;
    logic [CNT_W-1:0] rc_q;
    logic [CNT_W-1:0] wr_q;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    // Transient states resolve in the cycle their timer reaches zero, so the
    // follow-on command is legal exactly T cycles after the one that started it.
    always_comb begin
        state = state_q;
        case (state_q)
            BS_ACTIVATING:  if (rcd_q == '0) state = BS_ACTIVE;
            BS_PRECHARGING: if (rp_q == '0)  state = BS_IDLE;
            BS_REFRESHING:  if (rfc_done)    state = BS_IDLE;
            default:        state = state_q;
        endcase
    end

    always_comb begin
        state_d = state;
        if (do_ref)
            state_d = BS_REFRESHING;
        else if (do_act)
            state_d = BS_ACTIVATING;
        else if (do_pre && (state == BS_ACTIVE))
            state_d = BS_PRECHARGING;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= BS_IDLE;
            row_q   <= '0;
            rcd_q   <= '0;
            rp_q    <= '0;
            ras_q   <= '0;
            rc_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (do_act)
                row_q <= act_row;
            else if (do_pre && (state == BS_ACTIVE))
                row_q <= '0;
            rcd_q <= do_act ? CNT_W'(T_RCD - 1) : dec(rcd_q);
            ras_q <= do_act ? CNT_W'(T_RAS - 1) : dec(ras_q);
            rc_q  <= do_act ? CNT_W'(T_RC - 1)  : dec(rc_q);
            rp_q  <= do_pre ? CNT_W'(T_RP - 1)  : dec(rp_q);
            wr_q  <= do_wr  ? CNT_W'(T_WR_REC - 1) : dec(wr_q);
        end
    end

    assign row        = row_q;
    assign act_tmr_ok = (rc_q == '0);
    assign pre_tmr_ok = (ras_q == '0) && (wr_q == '0);

endmodule

// File: rtl/dram_bank_timer.sv
// DDR4 per-bank timing tracker and refresh scheduler with command-legal query flags.
// Optional 32-bit event counters are built when DRAM_BANK_TIMER_PERF_EN is defined.
module dram_bank_timer
    import dram_pkg::*;
#(
    parameter int NUM_BANKS    = DEF_NUM_BANKS,
    parameter int ROW_W        = DEF_ROW_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RAS        = DEF_T_RAS,
    parameter int T_RC         = DEF_T_RC,
    parameter int T_WL         = DEF_T_WL,
    parameter int T_RL         = DEF_T_RL,
    parameter int T_BURST      = DEF_T_BURST,
    parameter int T_WR         = DEF_T_WR,
    parameter int T_WTR        = DEF_T_WTR,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int T_REFI       = DEF_T_REFI,
    parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
    input  logic             CLK,
    input  logic             nRST,
    dram_bank_timer_if.slave bus
`ifdef DRAM_BANK_TIMER_PERF_EN
    ,
    output logic [31:0]      perf_act_cnt,
    output logic [31:0]      perf_ref_cnt,
    output logic [31:0]      perf_illegal_cnt
`endif
);

    localparam int BANK_W   = $clog2(NUM_BANKS);
    localparam int WR_REC   = T_WL + T_BURST + T_WR;
    localparam int WR_TO_RD = T_WL + T_BURST + T_WTR;
    localparam int OWED_W   = $clog2(MAX_POSTPONE + 2);
    localparam int REFI_W   = $clog2(T_REFI + 1);
    localparam logic [OWED_W-1:0] OWED_MAX = OWED_W'(MAX_POSTPONE + 1);

    if (!fits_cnt(T_RCD, CNT_W) || !fits_cnt(T_RP, CNT_W) || !fits_cnt(T_RAS, CNT_W) ||
        !fits_cnt(T_RC, CNT_W) || !fits_cnt(T_RL, CNT_W) || !fits_cnt(WR_REC, CNT_W) ||
        !fits_cnt(WR_TO_RD, CNT_W) || !fits_cnt(T_RFC, CNT_W) || !fits_cnt(T_REFI, CNT_W))
    begin : g_bad_timing
        $error("dram_bank_timer: timing parameter outside the CNT_W counter range");
    end

    bank_state_t          bank_state [NUM_BANKS];
    logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
    logic [NUM_BANKS-1:0] act_tmr_ok, pre_tmr_ok;
    logic [NUM_BANKS-1:0] is_idle, is_active, is_open, pre_ok;
    logic [NUM_BANKS-1:0] do_act, do_wr, do_pre;
    logic [BANK_W-1:0]    q;
    logic [CNT_W-1:0]     wtr_q, rfc_q;
    logic [REFI_W-1:0]    refi_q;
    logic [OWED_W-1:0]    owed_q, owed_d;
    logic                 rfc_done, refi_wrap, cmd_legal, issue, do_ref;
    logic                 can_act, can_rd, can_wr, can_pre, can_prea, can_ref;
    logic                 err_q, ovf_q;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    assign q        = bus.cmd_bank;
    assign rfc_done = (rfc_q == '0);
    assign issue    = bus.cmd_valid && cmd_legal;
    assign do_ref   = issue && (bus.cmd_op == OP_REF);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic hit;
        assign hit       = (q == BANK_W'(g));
        assign do_act[g] = issue && (bus.cmd_op == OP_ACT) && hit;
        assign do_wr[g]  = issue && (bus.cmd_op == OP_WR) && hit;
        assign do_pre[g] = issue && is_active[g] &&
                           (((bus.cmd_op == OP_PRE) && hit) || (bus.cmd_op == OP_PREA));

        dram_bank_fsm #(
            .ROW_W    (ROW_W),
            .CNT_W    (CNT_W),
            .T_RCD    (T_RCD),
            .T_RP     (T_RP),
            .T_RAS    (T_RAS),
            .T_RC     (T_RC),
            .T_WR_REC (WR_REC)
        ) u_fsm (
            .CLK        (CLK),
            .nRST       (nRST),
            .do_act     (do_act[g]),
            .do_wr      (do_wr[g]),
            .do_pre     (do_pre[g]),
            .do_ref     (do_ref),
            .rfc_done   (rfc_done),
            .act_row    (bus.cmd_row),
            .state      (bank_state[g]),
            .row        (bank_row[g]),
            .act_tmr_ok (act_tmr_ok[g]),
            .pre_tmr_ok (pre_tmr_ok[g])
        );

        assign is_idle[g]   = (bank_state[g] == BS_IDLE);
        assign is_active[g] = (bank_state[g] == BS_ACTIVE);
        assign is_open[g]   = (bank_state[g] == BS_ACTIVATING) || is_active[g];
        assign pre_ok[g]    = is_active[g] && pre_tmr_ok[g];
    end

    // Query flags depend only on registered state and cmd_bank, never on the op itself.
    assign can_act  = rfc_done && is_idle[q] && act_tmr_ok[q];
    assign can_rd   = rfc_done && is_active[q] && (wtr_q == '0);
    assign can_wr   = rfc_done && is_active[q];
    assign can_pre  = rfc_done && pre_ok[q];
    assign can_prea = rfc_done && (&(~is_open | pre_ok));
    assign can_ref  = rfc_done && (&is_idle);

    always_comb begin
        cmd_legal = 1'b0;
        case (bus.cmd_op)
            OP_NOP:  cmd_legal = 1'b1;
            OP_ACT:  cmd_legal = can_act;
            OP_RD:   cmd_legal = can_rd;
            OP_WR:   cmd_legal = can_wr;
            OP_PRE:  cmd_legal = can_pre || (rfc_done && is_idle[q]);
            OP_PREA: cmd_legal = can_prea;
            OP_REF:  cmd_legal = can_ref;
            default: cmd_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wtr_q <= '0;
            rfc_q <= '0;
            err_q <= 1'b0;
        end else begin
            wtr_q <= (issue && (bus.cmd_op == OP_WR)) ? CNT_W'(WR_TO_RD - 1) : dec(wtr_q);
            rfc_q <= do_ref ? CNT_W'(T_RFC - 1) : dec(rfc_q);
            err_q <= bus.cmd_valid && !cmd_legal;
        end
    end

    // A wrap and a REF in the same cycle cancel; otherwise owed saturates high, floors at zero.
    assign refi_wrap = (refi_q == REFI_W'(T_REFI - 1));

    always_comb begin
        owed_d = owed_q;
        if (refi_wrap && !do_ref) begin
            if (owed_q != OWED_MAX)
                owed_d = owed_q + OWED_W'(1);
        end else if (do_ref && !refi_wrap) begin
            if (owed_q != '0)
                owed_d = owed_q - OWED_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            refi_q <= '0;
            owed_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            refi_q <= refi_wrap ? '0 : refi_q + REFI_W'(1);
            owed_q <= owed_d;
            ovf_q  <= ovf_q || (owed_d == OWED_MAX);
        end
    end

`ifdef DRAM_BANK_TIMER_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_act_cnt     <= '0;
            perf_ref_cnt     <= '0;
            perf_illegal_cnt <= '0;
        end else begin
            if (|do_act)
                perf_act_cnt <= perf_act_cnt + 32'd1;
            if (do_ref)
                perf_ref_cnt <= perf_ref_cnt + 32'd1;
            if (bus.cmd_valid && !cmd_legal)
                perf_illegal_cnt <= perf_illegal_cnt + 32'd1;
        end
    end
`endif

    assign bus.can_act      = can_act;
    assign bus.can_rd       = can_rd;
    assign bus.can_wr       = can_wr;
    assign bus.can_pre      = can_pre;
    assign bus.can_prea     = can_prea;
    assign bus.can_ref      = can_ref;
    assign bus.bank_open    = is_open;
    assign bus.open_row     = is_open[q] ? bank_row[q] : '0;
    assign bus.ref_req      = (owed_q != '0);
    assign bus.ref_urgent   = (owed_q >= OWED_W'(MAX_POSTPONE));
    assign bus.err_illegal  = err_q;
    assign bus.ref_overflow = ovf_q;

endmodule

// File: doc/dram_bank_timer.md
Name: dram_bank_timer

Overview:
- Per-bank DDR4 timing tracker and refresh scheduler, between the command scheduler and the command/PHY driver.
- Tracks each bank's open/closed state and open row.
- Enforces tRCD/tRP/tRAS/tRC/tWR/tWTR/tRFC per bank and exposes "command legal now" flags for a queried bank.
- Schedules refresh with up to MAX_POSTPONE postponed REFs. Parametrised in bank count and all timings; replaces hard-coded timing constants in the scheduler.

Parameters:
- NUM_BANKS, 16, banks tracked (2^(bank-group bits + bank bits)); power of two ≥2
- ROW_W, 15, row address width
- CNT_W, 8, per-bank timing counter width; every timing below must be < 2^CNT_W
- T_RCD, 10, ACT to RD/WR, same bank
- T_RP, 10, PRE to ACT, same bank
- T_RAS, 45, ACT to PRE, same bank
- T_RC, 55, ACT to ACT, same bank
- T_WL, 10, write latency
- T_RL, 10, read latency (status only)
- T_BURST, 4, burst cycles
- T_WR, 13, write recovery
- T_WTR, 5, write-to-read turnaround, any bank
- T_RFC, 172, REF to any command
- T_REFI, 250, refresh interval
- MAX_POSTPONE, 8, REFs that may be owed before urgent

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command issued this cycle
- cmd_op  in  3  bank_op_t: NOP, ACT, RD, WR, PRE, PREA, REF
- cmd_bank  in  $clog2(NUM_BANKS)  target bank; also the query bank
- cmd_row  in  ROW_W  row for ACT
- can_act / can_rd / can_wr / can_pre  out  1 each  op legal now on cmd_bank
- can_prea / can_ref  out  1 each  op legal now (all banks)
- bank_open  out  NUM_BANKS  bank has an open row (ACTIVATING or ACTIVE)
- open_row  out  ROW_W  open row of cmd_bank; 0 if closed
- ref_req  out  1  at least one REF owed
- ref_urgent  out  1  owed ≥ MAX_POSTPONE
- err_illegal  out  1  registered one-cycle pulse: previous cycle's command was illegal
- ref_overflow  out  1  sticky; owed exceeded MAX_POSTPONE

Behaviour:
- Reset (async, nRST low): all banks IDLE, counters 0, rows 0, owed 0, interval counter 0. Flags: err_illegal=0, ref_overflow=0, can_act/can_prea/can_ref=1, can_rd/can_wr/can_pre=0.
- Per-bank FSM (bank_state_t): IDLE -ACT-> ACTIVATING -tRCD-> ACTIVE -PRE-> PRECHARGING -tRP-> IDLE. All banks IDLE -REF-> REFRESHING -tRFC-> IDLE.
- Timing: command issued in cycle n with constraint T makes the dependent command legal from cycle n+T, not before.
- Per-bank constraints:
  - RD/WR ≥ ACT+T_RCD.
  - PRE ≥ ACT+T_RAS, and ≥ last WR+T_WL+T_BURST+T_WR.
  - ACT ≥ PRE+T_RP, and ≥ previous ACT+T_RC.
- Global constraints: RD ≥ last WR (any bank)+T_WL+T_BURST+T_WTR. All ops ≥ REF+T_RFC.
- Legality:
  - ACT: bank IDLE, timers expired.
  - RD/WR: bank ACTIVE.
  - PRE: bank ACTIVE, timers expired; PRE on an IDLE bank is a legal no-op.
  - PREA: every open bank satisfies PRE.
  - REF: all banks IDLE and tRP expired.
- can_* outputs are combinational from registered state and cmd_bank only, never from cmd_valid/cmd_op.
- Illegal command: state unchanged; err_illegal=1 in the next cycle.
- Refresh interval counter:
  - Counts 0..T_REFI-1 and wraps; each wrap does owed++.
  - A legal REF does owed-- (floored at 0).
  - Wrap and legal REF in the same cycle: owed unchanged.
  - owed saturates at MAX_POSTPONE+1; reaching it sets ref_overflow, cleared only by reset.
- RD/WR to cmd_bank with a different open row: legal. Row-hit checking is the scheduler's job.
- Reset asserted mid-tRFC or mid-burst: reset state is immediate; no pending constraint survives.

Optional Feature:
DRAM_BANK_TIMER_PERF_EN:
- When defined, adds 32-bit wrapping outputs perf_act_cnt, perf_ref_cnt, perf_illegal_cnt, each incremented on its event and reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package (dram_pkg): bank_op_t and bank_state_t enums, NUM_BANKS derived from BANK_GROUP_BITS+BANK_BITS, default timing constants.
- Sub-module dram_bank_fsm, instantiated NUM_BANKS times via generate: one bank's state, row, and tRCD/tRAS/tRC/tRP/tWR counters.
- Top level holds the global tWTR/tRFC counters, refresh scheduler, query mux and error logic.

Test Plan:
- ACT bank 3 row 0x1A2B at cycle 0 → can_rd=0 cycles 1–9, 1 at cycle 10; open_row=0x1A2B; bank_open[3]=1.
- ACT b3 @0, WR b3 @40 → can_pre=0 until cycle 66, 1 at 67; PRE @67 → can_act=0 until 76, 1 at 77.
- WR b3 @20, query b5 (open) → can_rd=0 cycles 21–38, 1 at 39 (20+10+4+5).
- RD to IDLE bank 7 → err_illegal=1 next cycle only; bank 7 stays IDLE; no other state changes.
- No REF for 2250 cycles after reset → ref_req=1 @250, ref_urgent=1 @2000, ref_overflow=1 @2250. REF issued → owed 8, can_ref=0 for 172 cycles.
- REF issued on the same cycle as an interval wrap with owed=2 → owed stays 2. nRST pulsed mid-tRFC → all flags at reset values immediately.
